fpu_mul_result_queue: RTL and testbench
=======================================

// Module: fpu_mul_result_queue
// PURPOSE
//  Downstream capture stage for the combinational FP multiplier. Accepts each product
//  (result word plus exception/overflow/underflow flags) under valid/ready.
//  Buffers products in a DEPTH-entry FIFO and presents them to writeback under valid/ready.
//  Accumulates sticky status flags, FCSR-style, until software clears them.
// PARAMETERS
//  DEPTH  4   FIFO entries; power of two, >= 2; AW = $clog2(DEPTH)
//  W      64  result word width
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      product from multiplier valid
//  in_ready     out  1      queue can accept this cycle
//  in_result    in   W      multiplier result word
//  in_is_32bit  in   1      product is single precision (operands had zero upper halves)
//  in_exc       in   1      multiplier exception flag
//  in_ovf       in   1      multiplier overflow flag
//  in_unf       in   1      multiplier underflow flag
//  out_valid    out  1      head entry valid
//  out_ready    in   1      consumer takes head this cycle
//  out_result   out  W      head result word
//  out_is_32bit out  1      head precision tag
//  out_flags    out  3      head {exc,ovf,unf}
//  sticky_flags out  3      accumulated {exc,ovf,unf}
//  flags_clr    in   1      clear sticky_flags
//  count        out  AW+1   occupied entries, 0..DEPTH
// BEHAVIOUR
//  - Reset (async, rst_n=0): wr_ptr=rd_ptr=0, count=0, out_valid=0, in_ready=1,
//    sticky_flags=0, out_result=0, out_flags=0, out_is_32bit=0. Reset mid-transfer drops all entries.
//  - push = in_valid & in_ready; pop = out_valid & out_ready. Each is one beat per cycle.
//  - in_ready = (count != DEPTH); combinational from state only, never from out_ready.
//  - out_valid = (count != 0), except in the bypass case below. out_* driven from mem[rd_ptr].
//  - Stored word: if in_is_32bit, bits [W-1:32] are forced to 0 and bits [31:0] are kept.
//    Otherwise the word is stored unmodified.
//  - Pointers: AW bits, wrap DEPTH-1 -> 0 naturally.
//  - count: push only +1; pop only -1; push & pop together leaves count unchanged.
//  - Full (count=DEPTH): in_ready=0 even if pop this cycle; the freed slot is visible next cycle.
//  - Empty (count=0) without bypass: out_valid=0 and out_ready is ignored.
//  - Latency: a push in cycle N is visible on out_* in cycle N+1 (queue empty, no bypass).
//  - Output holds stable while out_valid & !out_ready.
//  - sticky_flags: on push, sticky |= {in_exc,in_ovf,in_unf}.
//    flags_clr with no push -> 0. flags_clr together with push -> {in_exc,in_ovf,in_unf};
//    the new event survives the clear.
//  - Flags not qualified by push (in_valid=0 or full) never touch sticky_flags.
//  - No other state machine: control is count/pointer driven (EMPTY/PARTIAL/FULL derived from count).
// CONFIGURATION
//  FPU_RESQ_BYPASS_EN defined: when count=0 and in_valid and out_ready, the input passes
//    combinationally to out_* with out_valid=1, in the same cycle.
//    - No FIFO write; count stays 0; sticky_flags still update.
//    - If count=0 and !out_ready, the entry is written normally.
//  FPU_RESQ_BYPASS_EN undefined: no combinational in->out path; minimum latency is 1 cycle.
// TESTING
//  1. Reset, push {result=64'h3FF0_0000_0000_0000, is_32bit=0, flags=000}, out_ready=1
//     -> out_valid=1 next cycle with the same word; count 1->0.
//  2. Push 32-bit product in_result=64'hDEAD_BEEF_3F80_0000, is_32bit=1
//     -> out_result=64'h0000_0000_3F80_0000, out_is_32bit=1.
//  3. out_ready=0, push 5 beats with DEPTH=4
//     -> in_ready=0 after 4th push, count=4, 5th beat not accepted.
//     Then pop 4 -> data in push order (wrap-around exercised), count=0.
//  4. Full queue, push and pop same cycle -> push refused, count=3 next cycle, in_ready=1.
//  5. Push ovf=1, then push unf=1 with flags_clr=1 in the same cycle
//     -> sticky 010 then 001; then flags_clr alone -> 000.
//  6. rst_n low while count=3 and out_valid=1
//     -> out_valid=0, count=0, sticky=000 immediately (async).
//     Bypass build: empty queue, out_ready=1, push -> out_valid same cycle, count stays 0.

Source files
------------

// File: rtl/fpu_mul_result_queue.sv
// Capture queue for FP multiplier products: DEPTH-entry FIFO with valid/ready on both sides and sticky status flags.
// Push-to-output latency is 1 cycle, or 0 with FPU_RESQ_BYPASS_EN when empty; in_ready drops only when full.
module fpu_mul_result_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_result,
  input  logic                   in_is_32bit,
  input  logic                   in_exc,
  input  logic                   in_ovf,
  input  logic                   in_unf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_result,
  output logic                   out_is_32bit,
  output logic [2:0]             out_flags,
  output logic [2:0]             sticky_flags,
  input  logic                   flags_clr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [W-1:0] result;
    logic         is_32bit;
    logic [2:0]   flags;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        in_entry;
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          accept;
  logic          push;
  logic          pop;
  logic          bypass;

  // Single-precision products carry garbage in the upper half; zero it before storing.
  always_comb begin
    in_entry.result   = in_is_32bit ? (in_result & W'(32'hFFFF_FFFF)) : in_result;
    in_entry.is_32bit = in_is_32bit;
    in_entry.flags    = {in_exc, in_ovf, in_unf};
  end

  assign in_ready = (count != FULL_CNT);
  assign accept   = in_valid & in_ready;

`ifdef FPU_RESQ_BYPASS_EN
  assign bypass = (count == '0) & in_valid & out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept & ~bypass;
  assign pop  = (count != '0) & out_ready;
  assign head = mem[rd_ptr];

  assign out_valid    = (count != '0) | bypass;
  assign out_result   = bypass ? in_entry.result   : head.result;
  assign out_is_32bit = bypass ? in_entry.is_32bit : head.is_32bit;
  assign out_flags    = bypass ? in_entry.flags    : head.flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      sticky_flags <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A flag event arriving with the clear is kept, so no exception is lost.
      if (flags_clr)   sticky_flags <= accept ? in_entry.flags : 3'b000;
      else if (accept) sticky_flags <= sticky_flags | in_entry.flags;
    end
  end

endmodule

// File: tb/tb_fpu_mul_result_queue.sv
// Bench for fpu_mul_result_queue: directed vector table, async reset and bypass sequences, then random traffic vs a queue model.
module tb_fpu_mul_result_queue;

  localparam int DEPTH = 4;
  localparam int W     = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_result;
  logic          in_is_32bit;
  logic          in_exc, in_ovf, in_unf;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_is_32bit;
  logic [2:0]    out_flags;
  logic [2:0]    sticky_flags;
  logic          flags_clr;
  logic [2:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_mul_result_queue #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_is_32bit(in_is_32bit), .in_exc(in_exc), .in_ovf(in_ovf), .in_unf(in_unf),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_is_32bit(out_is_32bit), .out_flags(out_flags),
    .sticky_flags(sticky_flags), .flags_clr(flags_clr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [63:0] res, input logic is32,
                       input logic [2:0] flg, input logic ordy, input logic clr);
    in_valid    = vld;
    in_result   = res;
    in_is_32bit = is32;
    {in_exc, in_ovf, in_unf} = flg;
    out_ready   = ordy;
    flags_clr   = clr;
  endtask

  typedef struct {
    logic        vld;
    logic [63:0] res;
    logic        is32;
    logic [2:0]  flg;
    logic        ordy;
    logic        clr;
    logic        e_rdy;
    logic        e_vld;
    logic [2:0]  e_cnt;
    logic [2:0]  e_stk;
    logic        chk;
    logic [63:0] e_res;
    logic        e_is32;
    logic [2:0]  e_flg;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic [63:0] res, input logic is32,
                              input logic [2:0] flg, input logic ordy, input logic clr,
                              input logic e_rdy, input logic e_vld, input logic [2:0] e_cnt,
                              input logic [2:0] e_stk, input logic chk, input logic [63:0] e_res,
                              input logic e_is32, input logic [2:0] e_flg);
    vec_t v;
    v.vld = vld; v.res = res; v.is32 = is32; v.flg = flg; v.ordy = ordy; v.clr = clr;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_cnt = e_cnt; v.e_stk = e_stk;
    v.chk = chk; v.e_res = e_res; v.e_is32 = e_is32; v.e_flg = e_flg;
    return v;
  endfunction

  typedef struct {
    logic [63:0] res;
    logic        is32;
    logic [2:0]  flg;
  } ent_t;

  ent_t       model_q[$];
  logic [2:0] model_stk;

  task automatic do_reset();
    drive(1'b0, 64'd0, 1'b0, 3'b000, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_sticky", 64'(sticky_flags), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_out_is_32bit", 64'(out_is_32bit), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
    model_stk = 3'b000;
  endtask

  localparam logic [63:0] A1 = 64'h1111_0000_0000_0001;
  localparam logic [63:0] A2 = 64'h2222_0000_0000_0002;
  localparam logic [63:0] A3 = 64'h3333_0000_0000_0003;
  localparam logic [63:0] A4 = 64'h4444_0000_0000_0004;
  localparam logic [63:0] A5 = 64'h5555_0000_0000_0005;
  localparam logic [63:0] A6 = 64'h6666_0000_0000_0006;
  localparam logic [63:0] R7 = 64'h7777_0000_0000_0007;
  localparam logic [63:0] R8 = 64'h8888_0000_0000_0008;

  initial begin
    vec_t vecs[17];
    rst_n = 1'b1;
    drive(1'b0, 64'd0, 1'b0, 3'b000, 1'b0, 1'b0);
    #2;
    do_reset();

`ifndef FPU_RESQ_BYPASS_EN
    // Expected values are observed just after the clock edge that consumes each row.
    vecs[0]  = mk(1, 64'h3FF0_0000_0000_0000, 0, 3'b000, 1, 0,  1, 1, 1, 3'b000, 1, 64'h3FF0_0000_0000_0000, 0, 3'b000);
    vecs[1]  = mk(0, 64'd0, 0, 3'b000, 1, 0,                   1, 0, 0, 3'b000, 0, 64'd0, 0, 3'b000);
    vecs[2]  = mk(1, 64'hDEAD_BEEF_3F80_0000, 1, 3'b000, 0, 0,  1, 1, 1, 3'b000, 1, 64'h0000_0000_3F80_0000, 1, 3'b000);
    vecs[3]  = mk(0, 64'd0, 0, 3'b000, 1, 0,                   1, 0, 0, 3'b000, 0, 64'd0, 0, 3'b000);
    vecs[4]  = mk(1, A1, 0, 3'b000, 0, 0,                      1, 1, 1, 3'b000, 1, A1, 0, 3'b000);
    vecs[5]  = mk(1, A2, 0, 3'b000, 0, 0,                      1, 1, 2, 3'b000, 1, A1, 0, 3'b000);
    vecs[6]  = mk(1, A3, 0, 3'b000, 0, 0,                      1, 1, 3, 3'b000, 1, A1, 0, 3'b000);
    vecs[7]  = mk(1, A4, 0, 3'b000, 0, 0,                      0, 1, 4, 3'b000, 1, A1, 0, 3'b000);
    vecs[8]  = mk(1, A5, 0, 3'b100, 0, 0,                      0, 1, 4, 3'b000, 1, A1, 0, 3'b000);
    vecs[9]  = mk(1, A6, 0, 3'b000, 1, 0,                      1, 1, 3, 3'b000, 1, A2, 0, 3'b000);
    vecs[10] = mk(0, 64'd0, 0, 3'b000, 1, 0,                   1, 1, 2, 3'b000, 1, A3, 0, 3'b000);
    vecs[11] = mk(0, 64'd0, 0, 3'b000, 1, 0,                   1, 1, 1, 3'b000, 1, A4, 0, 3'b000);
    vecs[12] = mk(0, 64'd0, 0, 3'b000, 1, 0,                   1, 0, 0, 3'b000, 0, 64'd0, 0, 3'b000);
    vecs[13] = mk(1, R7, 0, 3'b010, 1, 0,                      1, 1, 1, 3'b010, 1, R7, 0, 3'b010);
    vecs[14] = mk(1, R8, 0, 3'b001, 1, 1,                      1, 1, 1, 3'b001, 1, R8, 0, 3'b001);
    vecs[15] = mk(0, 64'd0, 0, 3'b000, 1, 1,                   1, 0, 0, 3'b000, 0, 64'd0, 0, 3'b000);
    vecs[16] = mk(0, 64'd0, 0, 3'b100, 1, 0,                   1, 0, 0, 3'b000, 0, 64'd0, 0, 3'b000);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].vld, vecs[i].res, vecs[i].is32, vecs[i].flg, vecs[i].ordy, vecs[i].clr);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_vld));
      check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
      check($sformatf("vec%0d_sticky", i), 64'(sticky_flags), 64'(vecs[i].e_stk));
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_out_result", i), out_result, vecs[i].e_res);
        check($sformatf("vec%0d_out_is_32bit", i), 64'(out_is_32bit), 64'(vecs[i].e_is32));
        check($sformatf("vec%0d_out_flags", i), 64'(out_flags), 64'(vecs[i].e_flg));
      end
    end
`else
    // Empty queue with a ready consumer: product appears combinationally, nothing is stored.
    @(negedge clk);
    drive(1'b1, 64'hDEAD_BEEF_1234_5678, 1'b1, 3'b100, 1'b1, 1'b0);
    #1;
    check("byp_out_valid", 64'(out_valid), 64'd1);
    check("byp_out_result", out_result, 64'h0000_0000_1234_5678);
    check("byp_out_flags", 64'(out_flags), 64'(3'b100));
    check("byp_count_same", 64'(count), 64'd0);
    @(posedge clk);
    #1;
    check("byp_count_after", 64'(count), 64'd0);
    check("byp_sticky", 64'(sticky_flags), 64'(3'b100));
    @(negedge clk);
    drive(1'b1, A1, 1'b0, 3'b000, 1'b0, 1'b0);
    #1;
    check("byp_stall_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("byp_stall_count", 64'(count), 64'd1);
    check("byp_stall_out_result", out_result, A1);
    @(negedge clk);
    drive(1'b0, 64'd0, 1'b0, 3'b000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("byp_drain_count", 64'(count), 64'd0);
`endif

    // Async reset with three entries held: state must clear without a clock edge.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 64'(i + 1), 1'b0, 3'b111, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 64'd0, 1'b0, 3'b000, 1'b0, 1'b0);
    #1;
    check("prerst_count", 64'(count), 64'd3);
    check("prerst_out_valid", 64'(out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_sticky", 64'(sticky_flags), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    do_reset();

    // Random traffic against a queue model; compare before each edge, then advance the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        vld, ordy, clr, is32, byp, acc;
      logic [63:0] res, eres;
      logic [2:0]  flg;
      @(negedge clk);
      vld  = ($urandom_range(0, 9) < 6);
      ordy = ($urandom_range(0, 9) < (cyc < 1500 ? 4 : 7));
      clr  = ($urandom_range(0, 9) == 0);
      is32 = $urandom_range(0, 1) == 1;
      flg  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      res  = {32'($urandom), 32'($urandom)};
      drive(vld, res, is32, flg, ordy, clr);
      eres = is32 ? {32'd0, res[31:0]} : res;
`ifdef FPU_RESQ_BYPASS_EN
      byp = (model_q.size() == 0) && vld && ordy;
`else
      byp = 1'b0;
`endif
      acc = vld && (model_q.size() != DEPTH);
      #1;
      check("rnd_in_ready", 64'(in_ready), 64'(model_q.size() != DEPTH));
      check("rnd_out_valid", 64'(out_valid), 64'(model_q.size() != 0 || byp));
      check("rnd_count", 64'(count), 64'(model_q.size()));
      check("rnd_sticky", 64'(sticky_flags), 64'(model_stk));
      if (byp) begin
        check("rnd_byp_result", out_result, eres);
        check("rnd_byp_flags", 64'(out_flags), 64'(flg));
      end else if (model_q.size() != 0) begin
        check("rnd_out_result", out_result, model_q[0].res);
        check("rnd_out_is_32bit", 64'(out_is_32bit), 64'(model_q[0].is32));
        check("rnd_out_flags", 64'(out_flags), 64'(model_q[0].flg));
      end
      @(posedge clk);
      if (ordy && model_q.size() != 0) void'(model_q.pop_front());
      if (acc && !byp) begin
        ent_t e;
        e.res = eres; e.is32 = is32; e.flg = flg;
        model_q.push_back(e);
      end
      if (clr) model_stk = acc ? flg : 3'b000;
      else if (acc) model_stk = model_stk | flg;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
